// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: opcodes, default sizes and request type shared by alu_arbiter
package alu_arb_pkg;
  localparam int DEFAULT_NUM_REQ = 2;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_OPCODE_LENGTH = 4;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b1100;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] a;
    logic [DEFAULT_DATA_WIDTH-1:0] b;
    logic [DEFAULT_OPCODE_LENGTH-1:0] op;
  } alu_req_t;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; undefined opcodes yield zero, SLT is unsigned
module alu import alu_arb_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OPCODE_LENGTH = DEFAULT_OPCODE_LENGTH
)(
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ALUResult
);
  always_comb
    case (Operation)
      OPCODE_LENGTH'(ALU_AND): ALUResult = SrcA & SrcB;
      OPCODE_LENGTH'(ALU_OR):  ALUResult = SrcA | SrcB;
      OPCODE_LENGTH'(ALU_ADD): ALUResult = SrcA + SrcB;
      OPCODE_LENGTH'(ALU_XOR): ALUResult = SrcA ^ SrcB;
      OPCODE_LENGTH'(ALU_SUB): ALUResult = SrcA - SrcB;
      OPCODE_LENGTH'(ALU_SLT): ALUResult = DATA_WIDTH'(SrcA < SrcB);
      OPCODE_LENGTH'(ALU_EQ):  ALUResult = DATA_WIDTH'(SrcA == SrcB);
      default:                 ALUResult = '0;
    endcase
endmodule

// File: rtl/alu_grant_picker.sv
// alu_grant_picker: one-hot grant among valid requesters while the slot is free
// ALU_ARB_RR_EN: search starts at rr_ptr (round-robin); otherwise lowest index wins
module alu_grant_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  input  logic                slot_free,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] gnt_idx
);
  logic [ID_WIDTH-1:0] j;
  logic found;
`ifndef ALU_ARB_RR_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
`endif
  always_comb begin
    grant = '0;
    gnt_idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ALU_ARB_RR_EN
      j = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
`else
      j = ID_WIDTH'(k);
`endif
      if (!found && slot_free && req_valid[j]) begin
        grant[j] = 1'b1;
        gnt_idx = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu among NUM_REQ requesters with a one-entry tagged result register
// ALU_ARB_RR_EN selects round-robin grant; default build is fixed lowest-index priority
module alu_arbiter import alu_arb_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OPCODE_LENGTH = DEFAULT_OPCODE_LENGTH,
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
)(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_b,
  input  logic [NUM_REQ-1:0][OPCODE_LENGTH-1:0] req_op,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [DATA_WIDTH-1:0]                 rsp_result,
  output logic [ID_WIDTH-1:0]                   rsp_id
);
  logic slot_free, accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_WIDTH-1:0] gnt_idx, rr_ptr;
  logic [DATA_WIDTH-1:0] alu_result;
  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = rst_n ? grant : '0;
  assign accept = |req_ready;
  alu_grant_picker #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_picker (
    .req_valid(req_valid),
    .rr_ptr(rr_ptr),
    .slot_free(slot_free),
    .grant(grant),
    .gnt_idx(gnt_idx)
  );
  alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
    .SrcA(req_a[gnt_idx]),
    .SrcB(req_b[gnt_idx]),
    .Operation(req_op[gnt_idx]),
    .ALUResult(alu_result)
  );
  // accept takes precedence over drain so a simultaneous drain+accept reloads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_id <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_result <= alu_result;
      rsp_id <= gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (accept) rr_ptr <= (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
`else
  assign rr_ptr = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; grant model follows ALU_ARB_RR_EN
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  localparam int N = 2;
  typedef struct {
    int id;
    logic [31:0] r;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rsp_ready = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0][31:0] req_a, req_b;
  logic [N-1:0][3:0] req_op;
  logic rsp_valid;
  logic [31:0] rsp_result;
  logic [0:0] rsp_id;
  alu_req_t rq [N];
  exp_t q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int mptr = 0;
  int win, j;
  logic free;
  logic [N-1:0] er;

  alu_arbiter u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) begin
      req_a[i] = rq[i].a;
      req_b[i] = rq[i].b;
      req_op[i] = rq[i].op;
    end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_XOR: return a ^ b;
      ALU_SUB: return a - b;
      ALU_SLT: return (a < b) ? 32'd1 : 32'd0;
      ALU_EQ:  return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [0:0] i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op, input logic v);
    rq[i] = '{a: a, b: b, op: op};
    req_valid[i] = v;
  endtask

  // reference model: expected grant, result register contents and pointer
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr = 0;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_result", rsp_result, 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
    end else begin
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rsp_result", rsp_result, q[0].r);
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      end
      free = (q.size() == 0) || rsp_ready;
      win = -1;
      for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_RR_EN
        j = (mptr + k) % N;
`else
        j = k;
`endif
        if (win < 0 && req_valid[1'(j)]) win = j;
      end
      er = (free && win >= 0) ? N'(1) << win : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      if (q.size() != 0 && rsp_ready) void'(q.pop_front());
      if (er != '0) begin
        q.push_back('{id: win, r: ref_alu(rq[1'(win)].a, rq[1'(win)].b, rq[1'(win)].op)});
`ifdef ALU_ARB_RR_EN
        mptr = (win + 1) % N;
`endif
      end
    end
  end

  logic [0:0]  e_id [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] e_a  [6] = '{32'd0, 32'hFFFF_FFFF, 32'd9, 32'd123, 32'hCC, 32'hDEAD_BEEF};
  logic [31:0] e_b  [6] = '{32'd1, 32'd1, 32'd9, 32'd456, 32'hAA, 32'h1};
  logic [3:0]  e_op [6] = '{ALU_SUB, ALU_SLT, ALU_EQ, 4'hF, ALU_OR, ALU_ADD};

  initial begin
    for (int i = 0; i < N; i++) rq[i] = '0;
    rsp_ready = 1'b1;
    step(2);
    rst_n = 1'b1;
    put(1'b0, 32'd5, 32'd7, ALU_ADD, 1'b1);
    step();
    put(1'b0, 32'd0, 32'd0, ALU_AND, 1'b0);
    step(2);
    put(1'b0, 32'd10, 32'd3, ALU_SUB, 1'b1);
    put(1'b1, 32'hF0, 32'h0F, ALU_XOR, 1'b1);
    step(4);
    put(1'b0, 32'd0, 32'd0, ALU_AND, 1'b0);
    put(1'b1, 32'd0, 32'd0, ALU_AND, 1'b0);
    step(2);
    rsp_ready = 1'b0;
    put(1'b0, 32'd1, 32'd2, ALU_ADD, 1'b1);
    step();
    put(1'b0, 32'd0, 32'd0, ALU_AND, 1'b0);
    put(1'b1, 32'd6, 32'd3, ALU_AND, 1'b1);
    step(3);
    rsp_ready = 1'b1;
    step();
    put(1'b1, 32'd0, 32'd0, ALU_AND, 1'b0);
    step(2);
    for (int i = 0; i < 6; i++) begin
      put(e_id[i], e_a[i], e_b[i], e_op[i], 1'b1);
      step();
      put(e_id[i], 32'd0, 32'd0, ALU_AND, 1'b0);
    end
    step(2);
    rsp_ready = 1'b0;
    put(1'b1, 32'd4, 32'd4, ALU_ADD, 1'b1);
    step();
    put(1'b1, 32'd0, 32'd0, ALU_AND, 1'b0);
    step(2);
    put(1'b0, 32'd2, 32'd3, ALU_ADD, 1'b1);
    put(1'b1, 32'd7, 32'd1, ALU_SUB, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(rsp_valid), 32'd0);
    chk("async_result", rsp_result, 32'd0);
    chk("async_id", 32'(rsp_id), 32'd0);
    chk("async_ready", 32'(req_ready), 32'd0);
    step(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    step();
    put(1'b0, 32'd0, 32'd0, ALU_AND, 1'b0);
    put(1'b1, 32'd0, 32'd0, ALU_AND, 1'b0);
    step(3);
    chk("drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
